// File: rtl/seg7_frame_decoder.sv
// Decodes a strobed 7-segment bus back to hex digits, assembles FRAME_LEN digits
// into frames and flags when a completed frame equals the one before it.
module seg7_frame_decoder #(
    parameter int FRAME_LEN = 8,
    parameter int TIMEOUT   = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [6:0]             seg_in,
    input  logic                   seg_stb,
    output logic [3:0]             digit,
    output logic                   digit_valid,
    output logic                   digit_err,
    output logic [4*FRAME_LEN-1:0] frame_data,
    output logic                   frame_done,
    output logic                   frame_match,
    output logic                   timeout,
    output logic [7:0]             err_cnt
);
    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        CHECK
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d, wr_idx;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic                   wr_en, frame_load, timeout_d;
    logic                   dec_legal, stb_ok, stb_bad;
    logic [3:0]             dec_hex;
    logic [4*FRAME_LEN-1:0] buf_q, prev_frame_q;
    logic                   prev_valid_q;
    logic [3:0]             digit_q;
    logic                   digit_valid_q, digit_err_q;
    logic [4*FRAME_LEN-1:0] frame_data_q;
    logic                   frame_done_q, frame_match_q, timeout_q;
    logic [7:0]             err_cnt_q;

    // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        dec_legal = 1'b1;
        dec_hex   = 4'h0;
        case (seg_in)
            7'b1111110: dec_hex = 4'h0;
            7'b0110000: dec_hex = 4'h1;
            7'b1101101: dec_hex = 4'h2;
            7'b1111001: dec_hex = 4'h3;
            7'b0110011: dec_hex = 4'h4;
            7'b1011011: dec_hex = 4'h5;
            7'b1011111: dec_hex = 4'h6;
            7'b1110000: dec_hex = 4'h7;
            7'b1111111: dec_hex = 4'h8;
            7'b1111011: dec_hex = 4'h9;
            7'b1110111: dec_hex = 4'hA;
            7'b0011111: dec_hex = 4'hB;
            7'b1001110: dec_hex = 4'hC;
            7'b0111101: dec_hex = 4'hD;
            7'b1001111: dec_hex = 4'hE;
            7'b1000111: dec_hex = 4'hF;
            default:    dec_legal = 1'b0;
        endcase
    end

    assign stb_ok  = seg_stb && dec_legal;
    assign stb_bad = seg_stb && !dec_legal;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        wr_en      = 1'b0;
        wr_idx     = idx_q;
        frame_load = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE, CHECK: begin
                // CHECK publishes the frame and then behaves exactly like IDLE.
                frame_load = (state_q == CHECK);
                state_d    = IDLE;
                idx_d      = '0;
                timer_d    = '0;
                if (stb_ok) begin
                    wr_en   = 1'b1;
                    wr_idx  = '0;
                    idx_d   = IDX_W'(1);
                    state_d = (FRAME_LEN == 1) ? CHECK : COLLECT;
                end
            end
            COLLECT: begin
                if (stb_ok) begin
                    wr_en   = 1'b1;
                    timer_d = '0;
                    if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
                        state_d = CHECK;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (stb_bad) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    timer_d = '0;
                end else if (timer_q == TMR_W'(TIMEOUT - 2)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                    idx_d     = '0;
                    timer_d   = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            timer_q       <= '0;
            digit_q       <= '0;
            digit_valid_q <= 1'b0;
            digit_err_q   <= 1'b0;
            frame_data_q  <= '0;
            frame_done_q  <= 1'b0;
            frame_match_q <= 1'b0;
            timeout_q     <= 1'b0;
            err_cnt_q     <= '0;
            prev_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            digit_valid_q <= stb_ok;
            digit_err_q   <= stb_bad;
            frame_done_q  <= frame_load;
            timeout_q     <= timeout_d;
            if (stb_ok) begin
                digit_q <= dec_hex;
            end
            if (stb_bad && err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
            if (frame_load) begin
                frame_data_q  <= buf_q;
                frame_match_q <= prev_valid_q && (buf_q == prev_frame_q);
                prev_valid_q  <= 1'b1;
            end
        end
    end

    // NOTE: the digit buffer and previous frame carry no reset; prev_valid_q gates their use and every slot is written before a frame is published.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[{wr_idx, 2'b00} +: 4] <= dec_hex;
        end
        if (frame_load) begin
            prev_frame_q <= buf_q;
        end
    end

    assign digit       = digit_q;
    assign digit_valid = digit_valid_q;
    assign digit_err   = digit_err_q;
    assign frame_data  = frame_data_q;
    assign frame_done  = frame_done_q;
    assign frame_match = frame_match_q;
    assign timeout     = timeout_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Scoreboard bench for seg7_frame_decoder: a behavioural model predicts per-strobe,
// frame and timeout events with cycle stamps; a negedge monitor pops and compares.
module tb_seg7_frame_decoder;
    localparam int FRAME_LEN = 8;
    localparam int TIMEOUT   = 20;
    localparam int FW        = 4 * FRAME_LEN;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    seg_in = '0;
    logic          seg_stb = 1'b0;
    logic [3:0]    digit;
    logic          digit_valid, digit_err;
    logic [FW-1:0] frame_data;
    logic          frame_done, frame_match, timeout;
    logic [7:0]    err_cnt;

    seg7_frame_decoder #(.FRAME_LEN(FRAME_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .seg_stb     (seg_stb),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_err   (digit_err),
        .frame_data  (frame_data),
        .frame_done  (frame_done),
        .frame_match (frame_match),
        .timeout     (timeout),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_err_pulses = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {int c; bit legal; logic [3:0] d; logic [7:0] errs;} stb_ev_t;
    typedef struct {int c; logic [FW-1:0] data; bit match;} frm_ev_t;

    stb_ev_t stb_q[$];
    frm_ev_t frm_q[$];
    int      to_q[$];

    logic [6:0] seg_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    // Behavioural model: frame contents as a queue of digits, timing as edge numbers.
    logic [3:0]    m_part[$];
    logic [FW-1:0] m_prev;
    bit            m_prev_valid;
    int            m_last;
    logic [3:0]    m_digit;
    int            m_errs;

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (seg_tab[i] == p) return i;
        return -1;
    endfunction

    function automatic void model_reset();
        m_part.delete();
        m_prev_valid = 1'b0;
        m_digit      = 4'h0;
        m_errs       = 0;
        m_last       = 0;
    endfunction

    function automatic void model_edge(input int c, input bit stb, input logic [6:0] pat);
        int            v;
        logic [FW-1:0] f;
        bit            match;
        if (stb) begin
            v = lookup(pat);
            if (v >= 0) begin
                m_digit = 4'(v);
                stb_q.push_back('{c, 1'b1, m_digit, 8'(m_errs)});
                m_part.push_back(m_digit);
                m_last = c;
                if (m_part.size() == FRAME_LEN) begin
                    f = '0;
                    foreach (m_part[k]) f[4*k +: 4] = m_part[k];
                    match = m_prev_valid && (f == m_prev);
                    frm_q.push_back('{c + 1, f, match});
                    m_prev       = f;
                    m_prev_valid = 1'b1;
                    m_part.delete();
                end
            end else begin
                if (m_errs < 255) m_errs++;
                stb_q.push_back('{c, 1'b0, m_digit, 8'(m_errs)});
                m_part.delete();
            end
        end else if (m_part.size() > 0 && (c - m_last) == TIMEOUT - 1) begin
            to_q.push_back(c);
            m_part.delete();
        end
    endfunction

    always @(negedge clk) begin
        stb_ev_t s;
        frm_ev_t f;
        int      t;
        check("valid_err_exclusive", {63'd0, digit_valid && digit_err}, 64'd0);
        if (digit_valid || digit_err) begin
            if (digit_err) n_err_pulses++;
            check("spurious_digit_event", {63'd0, stb_q.size() != 0}, 64'd1);
            if (stb_q.size() != 0) begin
                s = stb_q.pop_front();
                check("digit_cycle", cyc, s.c);
                check("digit_valid", digit_valid, s.legal);
                check("digit_err", digit_err, !s.legal);
                check("digit", digit, s.d);
                check("err_cnt", err_cnt, s.errs);
            end
        end
        if (frame_done) begin
            check("spurious_frame_done", {63'd0, frm_q.size() != 0}, 64'd1);
            if (frm_q.size() != 0) begin
                f = frm_q.pop_front();
                check("frame_cycle", cyc, f.c);
                check("frame_data", frame_data, f.data);
                check("frame_match", frame_match, f.match);
            end
        end
        if (timeout) begin
            check("spurious_timeout", {63'd0, to_q.size() != 0}, 64'd1);
            if (to_q.size() != 0) begin
                t = to_q.pop_front();
                check("timeout_cycle", cyc, t);
            end
        end
    end

    task automatic cycle(input bit stb, input logic [6:0] pat);
        seg_stb = stb;
        seg_in  = pat;
        model_edge(cyc + 1, stb, pat);
        @(posedge clk);
        #1;
        seg_stb = 1'b0;
    endtask

    task automatic send_digit(input logic [3:0] d, input int gap);
        cycle(1'b1, seg_tab[d]);
        repeat (gap) cycle(1'b0, 7'd0);
    endtask

    task automatic send_frame(input logic [FW-1:0] f, input int gap);
        for (int k = 0; k < FRAME_LEN; k++) send_digit(f[4*k +: 4], gap);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        seg_stb = 1'b0;
        seg_in  = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("rst_digit", digit, 0);
        check("rst_digit_valid", digit_valid, 0);
        check("rst_digit_err", digit_err, 0);
        check("rst_frame_data", frame_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_match", frame_match, 0);
        check("rst_timeout", timeout, 0);
        check("rst_err_cnt", err_cnt, 0);
    endtask

    initial begin
        logic [FW-1:0] fa, fb, fr;
        int            errs_before;
        fa = 32'h91403091;
        fb = 32'h81403091;

        do_reset();
        repeat (2) cycle(1'b0, 7'd0);

        // Reference frame, one strobe every 4th cycle.
        send_frame(fa, 3);
        check("frameA_data", frame_data, 32'h91403091);
        check("frameA_match", frame_match, 0);

        // Immediate repeat with back-to-back strobes, then a modified frame.
        send_frame(fa, 0);
        cycle(1'b0, 7'd0);
        check("repeat_match", frame_match, 1);
        send_frame(fb, 1);
        check("frameB_data", frame_data, 32'h81403091);
        check("frameB_match", frame_match, 0);

        // Partial frame aborted by an illegal pattern.
        send_digit(4'h1, 1);
        send_digit(4'h9, 1);
        send_digit(4'h0, 1);
        cycle(1'b1, 7'b1010101);
        cycle(1'b0, 7'd0);
        check("abort_err_cnt", err_cnt, 1);
        send_frame(fa, 2);

        // Timeout after three digits, then a fresh frame from slot 0.
        send_digit(4'h3, 0);
        send_digit(4'h5, 0);
        send_digit(4'h7, 0);
        repeat (25) cycle(1'b0, 7'd0);
        send_frame(fb, 2);

        // Reset mid-frame clears the previous-frame history.
        for (int k = 0; k < 5; k++) send_digit(fa[4*k +: 4], 1);
        do_reset();
        send_frame(fa, 1);
        cycle(1'b0, 7'd0);
        check("post_reset_match", frame_match, 0);

        // Saturation of the error counter with back-to-back blank patterns.
        errs_before = n_err_pulses;
        for (int i = 0; i < 300; i++) cycle(1'b1, 7'd0);
        repeat (2) cycle(1'b0, 7'd0);
        check("sat_err_cnt", err_cnt, 255);
        check("sat_err_pulses", n_err_pulses - errs_before, 300);
        check("sat_digit_held", digit, 4'h9);

        // Randomised frames: frequent repeats, occasional illegal patterns and long gaps.
        fr = '0;
        for (int f = 0; f < 30; f++) begin
            if (f == 0 || $urandom_range(0, 2) != 0) begin
                for (int k = 0; k < FRAME_LEN; k++) fr[4*k +: 4] = 4'($urandom_range(0, 15));
            end
            for (int k = 0; k < FRAME_LEN; k++) begin
                if ($urandom_range(0, 39) == 0) cycle(1'b1, 7'($urandom));
                if ($urandom_range(0, 63) == 0) repeat ($urandom_range(15, 24)) cycle(1'b0, 7'd0);
                send_digit(fr[4*k +: 4], $urandom_range(0, 3));
            end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 5)) cycle(1'b0, 7'd0);
        end

        repeat (TIMEOUT + 10) cycle(1'b0, 7'd0);
        check("pending_digit_events", stb_q.size(), 0);
        check("pending_frame_events", frm_q.size(), 0);
        check("pending_timeouts", to_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
